// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ byte producers
module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int CLK_FREQ = 50000000,
    parameter int UART_BPS = 9600,
    parameter int EN_HOLD  = 4,
    parameter int GAP_CYC  = 4
) (
    input  logic               I_clk,
    input  logic               I_rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] din,
    output logic [N_REQ-1:0]   ack,
    output logic [2:0]         grant_id,
    output logic               busy,
    output logic               uart_en,
    output logic [7:0]         uart_din
);

    localparam int BPS_CNT  = CLK_FREQ / UART_BPS;
    localparam int WAIT_CYC = 10 * BPS_CNT + 4;
    localparam logic [19:0] HOLD_LOAD = 20'(EN_HOLD - 1);
    localparam logic [19:0] WAIT_LOAD = 20'(WAIT_CYC - EN_HOLD);
    localparam logic [19:0] GAP_LOAD  = 20'(GAP_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT,
        S_GAP
    } state_t;

    state_t      state;
    logic [19:0] cnt;
    logic [2:0]  ptr;
    logic [7:0]  req_pad;
    logic [63:0] din_pad;
    logic [3:0]  scan;
    logic        sel_found;
    logic [2:0]  sel_idx;

    assign req_pad = 8'(req);
    assign din_pad = 64'(din);

    // First requesting index at or after the pointer, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = 3'd0;
        scan      = 4'd0;
        for (int k = 0; k < N_REQ; k++) begin
            scan = 4'(ptr) + 4'(k);
            if (scan >= 4'(N_REQ)) begin
                scan = scan - 4'(N_REQ);
            end
            if (!sel_found && req_pad[scan[2:0]]) begin
                sel_found = 1'b1;
                sel_idx   = scan[2:0];
            end
        end
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= '0;
            ack      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            uart_en  <= 1'b0;
            uart_din <= 8'h00;
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        state    <= S_GRANT;
                        ack      <= N_REQ'(8'd1 << sel_idx);
                        uart_din <= din_pad[{sel_idx, 3'b000} +: 8];
                        grant_id <= sel_idx;
                        ptr      <= (sel_idx == 3'(N_REQ - 1)) ? 3'd0 : sel_idx + 3'd1;
                        busy     <= 1'b1;
                    end
                end
                S_GRANT: begin
                    state   <= S_START;
                    uart_en <= 1'b1;
                    cnt     <= HOLD_LOAD;
                end
                S_START: begin
                    if (cnt == 20'd0) begin
                        state   <= S_WAIT;
                        uart_en <= 1'b0;
                        cnt     <= WAIT_LOAD;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_WAIT: begin
                    // Leaves on the cycle the count would reach zero, so WAIT lasts WAIT_LOAD cycles.
                    if (cnt <= 20'd1) begin
                        state <= S_GAP;
                        cnt   <= GAP_LOAD;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                S_GAP: begin
                    if (cnt == 20'd0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 20'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one uart_tx transmitter among N_REQ byte producers, such as a status reporter, debug printer and command responder. It picks a requester by round-robin and latches that requester's byte. It then produces the rising-edge start on uart_en that uart_tx expects, holds uart_din stable, and waits one full frame time before accepting the next byte. uart_tx has no busy output, so frame completion is tracked here with a cycle counter.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_FREQ, 50000000, system clock frequency in Hz; must match uart_tx
UART_BPS, 9600, baud rate; must match uart_tx
EN_HOLD, 4, cycles uart_en is held high per byte (>=2)
GAP_CYC, 4, idle cycles after each frame before the next arbitration (>=2)

Ports:
I_clk  in  1  system clock; single clock domain
I_rst  in  1  synchronous reset, active-high
req  in  N_REQ  per-requester request; level, held until ack
din  in  8*N_REQ  requester i byte at din[8*i+7:8*i]; valid while req[i]=1
ack  out  N_REQ  one-cycle pulse: byte of requester i accepted
grant_id  out  3  index of the requester currently or most recently served
busy  out  1  high whenever state is not IDLE
uart_en  out  1  to uart_tx uart_en
uart_din  out  8  to uart_tx uart_din

Behaviour:
- localparam BPS_CNT = CLK_FREQ/UART_BPS; WAIT_CYC = 10*BPS_CNT + 4 (52084 at defaults). Wait counter is 20 bits and counts down to 0 with no wrap.
- Reset (synchronous, I_rst=1 at a posedge): state IDLE, ack=0, uart_en=0, uart_din=8'h00, grant_id=0, busy=0, round-robin pointer=0, counters=0. Reset may occur mid-frame; uart_tx is reset from the same system reset, so no partial-frame recovery is needed.
- State IDLE: if any req bit is set, select the first set bit at or after the pointer, scanning upward with wrap modulo N_REQ. Go to GRANT. No req bits set: stay in IDLE.
- State GRANT (1 cycle):
  - uart_din <= selected din slice; grant_id <= index; ack[index]=1 for this cycle only.
  - pointer <= index+1, wrapping to 0 at N_REQ.
  - Go to START.
- State START (EN_HOLD cycles): uart_en=1; then drop uart_en to 0 and go to WAIT. The counter loads WAIT_CYC-EN_HOLD.
- State WAIT: uart_en=0 and uart_din held. When the counter reaches 0, go to GAP.
  - The WAIT_CYC total measured from the uart_en rise covers the uart_tx 2-flop edge detect, start bit, 8 data bits and full stop bit.
- State GAP (GAP_CYC cycles): uart_en=0, uart_din held, then go to IDLE. This guarantees uart_en is low long enough for uart_tx to see a fresh rising edge.
- Timing rules:
  - uart_din changes only in GRANT and is otherwise constant from GRANT until the next GRANT.
  - uart_en rises exactly 1 cycle after GRANT.
  - ack latency: 1 cycle after req is seen in IDLE.
  - Byte-to-byte period for back-to-back traffic: 1+EN_HOLD+(WAIT_CYC-EN_HOLD)+GAP_CYC+1 = WAIT_CYC+GAP_CYC+2 cycles.
- Requester rules:
  - Requester i must deassert req[i], or present its next byte, in the cycle after ack[i].
  - req is sampled only in IDLE. A req held across frames is served again only when round-robin reaches it.
  - req changes outside IDLE are ignored.
- Simultaneous requests: exactly one is granted per frame; the others stay pending with no loss.
- A requester whose req is set only during WAIT is considered at the next IDLE.
- The din slice of a non-granted requester is never sampled.

Test Plan:
- Single request: reset, then req=4'b0001, din[7:0]=8'h55.
  - Expect ack[0] one cycle later and uart_en high 4 cycles with uart_din=8'h55.
  - Decoded line shows 0x55 at 9600 baud; busy low after 52084+4+2 cycles.
- Simultaneous requests: req=4'b0110 with bytes 8'hA1 (req 1) and 8'hA2 (req 2).
  - Expect grant order 1 then 2 and frames 0xA1 then 0xA2.
  - Second uart_en rise exactly WAIT_CYC+GAP_CYC+2 cycles after the first.
- Fairness: all four req held continuously, each with a distinct byte.
  - Expect grant_id sequence 0,1,2,3,0.
  - No requester served twice before the others are served once.
- Pointer wrap: serve requester 3, then assert req=4'b1001.
  - Expect requester 0 served before requester 3.
- Reset mid-frame: assert I_rst for 1 cycle during WAIT.
  - Next cycle: uart_en=0, uart_din=0, busy=0, ack=0.
  - A new request after reset is served normally with grant starting from index 0.
- Stability check: change din of the granted requester during WAIT.
  - uart_din stays unchanged and the transmitted byte equals the value latched in GRANT.
